// File: rtl/sram_port_ctrl_if.sv
// Request/response channel between an upstream client and sram_port_ctrl.
// master = client side, slave = controller side.
interface sram_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NUM_WMASKS-1:0] req_wmask;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_port_ctrl.sv
// Request-side controller for a single-port RW SRAM macro without a write mask.
// One operation in flight; partial-byte writes are done as read-modify-write.
// All macro-facing outputs come straight from flops.
module sram_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  sram_port_ctrl_if.slave       bus,
  output logic                  busy,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_CAP,
    RMW_RD,
    RMW_CAP,
    RMW_WR
  } state_t;

  state_t                state_q, state_d;
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic                  req_ready;
  logic                  accept;

  // Per byte: take the new write byte where the mask is set, otherwise keep the old byte.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [DATA_WIDTH-1:0] m;
    m = rdata;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (mask[i]) m[8*i +: 8] = wdata[8*i +: 8];
    end
    return m;
  endfunction

  // Upstream is only accepted when idle with no response waiting to drain.
  always_comb begin
    req_ready = (state_q == IDLE) && !rsp_valid_q;
    accept    = bus.req_valid && req_ready;
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = (state_q != IDLE);
  assign csb0          = csb0_q;
  assign web0          = web0_q;
  assign addr0         = addr0_q;
  assign din0          = din0_q;

  // Next-state logic: chip select defaults to deasserted so each access lasts one cycle.
  always_comb begin
    state_d     = state_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;

    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.req_we) begin
            state_d = RD;
            csb0_d  = 1'b0;
            addr0_d = bus.req_addr;
          end else if (&bus.req_wmask) begin
            state_d = RMW_WR;
            csb0_d  = 1'b0;
            web0_d  = 1'b0;
            addr0_d = bus.req_addr;
            din0_d  = bus.req_wdata;
          end else if (|bus.req_wmask) begin
            state_d = RMW_RD;
            csb0_d  = 1'b0;
            addr0_d = bus.req_addr;
            wdata_d = bus.req_wdata;
            wmask_d = bus.req_wmask;
          end
          // An all-zero mask is accepted and dropped without touching the macro.
        end
      end
      RD:      state_d = RD_CAP;
      RD_CAP: begin
        rsp_rdata_d = dout0;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RMW_RD:  state_d = RMW_CAP;
      RMW_CAP: begin
        din0_d  = merge_bytes(wdata_q, dout0, wmask_q);
        csb0_d  = 1'b0;
        web0_d  = 1'b0;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation and drops a pending response.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= IDLE;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Latched RMW write operands; pure data, so no reset.
  always_ff @(posedge clk0) begin
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
  end

endmodule
